// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register: a head register that drives out_data directly plus an
// optional skid register, with stall (hold), flush and asynchronous reset.
module pipe_skid_reg #(
  parameter int                 WIDTH     = 64,
  parameter logic [WIDTH-1:0]   NOP_VALUE = 64'h0000_0000_0000_0013,
  parameter logic [WIDTH-1:0]   KEEP_MASK = 64'hFFFF_FFFF_0000_0000,
  parameter int                 SKID_EN   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             hold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             push;
  logic             pop;

  // Without a skid slot, ONE can only take a new payload if the head leaves this cycle.
  if (SKID_EN != 0) begin : g_skid_ready
    assign in_ready = ~hold & (state != FULL);
  end else begin : g_noskid_ready
    assign in_ready = ~hold & ((state == EMPTY) | out_ready);
  end

  assign out_valid = ~hold & (state != EMPTY);
  assign out_data  = main_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= NOP_VALUE;
      skid_q <= NOP_VALUE;
      count  <= 2'd0;
    end else if (flush) begin
      // The PC field of the head survives so the flushed bubble still carries it.
      state  <= EMPTY;
      main_q <= (main_q & KEEP_MASK) | (NOP_VALUE & ~KEEP_MASK);
      skid_q <= NOP_VALUE;
      count  <= 2'd0;
    end else if (!hold) begin
      case (state)
        EMPTY: begin
          if (push) begin
            main_q <= in_data;
            state  <= ONE;
            count  <= 2'd1;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_q <= in_data;
          end else if (push && (SKID_EN != 0)) begin
            skid_q <= in_data;
            state  <= FULL;
            count  <= 2'd2;
          end else if (pop) begin
            state <= EMPTY;
            count <= 2'd0;
          end
        end
        FULL: begin
          if (pop) begin
            main_q <= skid_q;
            state  <= ONE;
            count  <= 2'd1;
          end
        end
        default: begin
          state <= EMPTY;
          count <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: SKID_EN=1 and SKID_EN=0 instances share stimulus and are
// checked every cycle against a queue model, plus hand-computed literal checks.
module tb_pipe_skid_reg;

  localparam logic [63:0] NOP  = 64'h0000_0000_0000_0013;
  localparam logic [63:0] KEEP = 64'hFFFF_FFFF_0000_0000;

  logic        clk = 0;
  logic        reset = 0;
  logic        flush = 0, hold = 0, in_valid = 0, out_ready = 0;
  logic [63:0] in_data = '0;
  logic        in_ready1, out_valid1, in_ready0, out_valid0;
  logic [63:0] out_data1, out_data0;
  logic [1:0]  count1, count0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.SKID_EN(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .count(count1));

  pipe_skid_reg #(.SKID_EN(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .count(count0));

  // Model: a FIFO of held payloads per instance plus the last value the head register kept.
  logic [63:0] q1[$];
  logic [63:0] q0[$];
  logic [63:0] last1 = NOP, last0 = NOP;

  function automatic logic m_rdy1();
    return ~hold & (q1.size() < 2);
  endfunction
  function automatic logic m_rdy0();
    return ~hold & ((q0.size() == 0) | out_ready);
  endfunction
  function automatic logic [63:0] m_head1();
    return (q1.size() > 0) ? q1[0] : last1;
  endfunction
  function automatic logic [63:0] m_head0();
    return (q0.size() > 0) ? q0[0] : last0;
  endfunction

  always @(posedge clk or posedge reset) begin
    logic p1, o1, p0, o0;
    if (reset) begin
      q1.delete(); q0.delete();
      last1 = NOP; last0 = NOP;
    end else if (flush) begin
      last1 = (m_head1() & KEEP) | (NOP & ~KEEP);
      last0 = (m_head0() & KEEP) | (NOP & ~KEEP);
      q1.delete(); q0.delete();
    end else begin
      p1 = in_valid & m_rdy1();
      o1 = ~hold & (q1.size() > 0) & out_ready;
      p0 = in_valid & m_rdy0();
      o0 = ~hold & (q0.size() > 0) & out_ready;
      if (o1) last1 = q1.pop_front();
      if (p1) q1.push_back(in_data);
      if (o0) last0 = q0.pop_front();
      if (p0) q0.push_back(in_data);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model in_ready1", 64'(in_ready1), 64'(m_rdy1()));
    chk("model out_valid1", 64'(out_valid1), 64'(~hold & ~reset & (q1.size() > 0)));
    chk("model count1", 64'(count1), 64'(q1.size()));
    chk("model out_data1", out_data1, m_head1());
    chk("model in_ready0", 64'(in_ready0), 64'(m_rdy0()));
    chk("model out_valid0", 64'(out_valid0), 64'(~hold & ~reset & (q0.size() > 0)));
    chk("model count0", 64'(count0), 64'(q0.size()));
    chk("model out_data0", out_data0, m_head0());
  end

  task automatic cyc(input logic v, input logic [63:0] d, input logic r,
                     input logic h = 1'b0, input logic f = 1'b0);
    in_valid = v; in_data = d; out_ready = r; hold = h; flush = f;
    @(posedge clk); #2;
  endtask

  initial begin
    #1 reset = 1;
    @(posedge clk); @(posedge clk); #2;
    chk("reset out_valid", 64'(out_valid1), 64'd0);
    chk("reset count", 64'(count1), 64'd0);
    chk("reset out_data", out_data1, NOP);
    reset = 0;

    // back-to-back streaming, first edge after reset already accepts
    for (int k = 1; k <= 4; k++) begin
      cyc(1, 64'h1000_0000_0000_0000 + 64'(k), 1);
      chk("b2b data", out_data1, 64'h1000_0000_0000_0000 + 64'(k));
      chk("b2b count", 64'(count1), 64'd1);
      chk("b2b in_ready", 64'(in_ready1), 64'd1);
    end
    cyc(0, 0, 1);
    chk("drain count", 64'(count1), 64'd0);
    chk("drain out_valid", 64'(out_valid1), 64'd0);
    chk("drain keeps main", out_data1, 64'h1000_0000_0000_0004);

    // backpressure
    cyc(1, 64'hAAAA, 0);
    chk("noskid ready low", 64'(in_ready0), 64'd0);
    cyc(1, 64'hBBBB, 0);
    chk("bp count", 64'(count1), 64'd2);
    chk("bp in_ready", 64'(in_ready1), 64'd0);
    chk("bp head A", out_data1, 64'hAAAA);
    cyc(0, 0, 1);
    chk("bp head B", out_data1, 64'hBBBB);
    chk("bp count1", 64'(count1), 64'd1);
    cyc(0, 0, 1);
    chk("bp empty", 64'(count1), 64'd0);

    // SKID_EN=0 push and pop in the same cycle
    cyc(1, 64'hCCCC, 0);
    cyc(1, 64'hDDDD, 1);
    chk("noskid pushpop data", out_data0, 64'hDDDD);
    chk("noskid pushpop count", 64'(count0), 64'd1);
    cyc(0, 0, 1);

    // flush while FULL
    cyc(1, 64'h0000_0040_DEAD_BEEF, 0);
    cyc(1, 64'h2222, 0);
    chk("full before flush", 64'(count1), 64'd2);
    cyc(1, 64'h3333, 1, 0, 1);
    chk("flush main", out_data1, 64'h0000_0040_0000_0013);
    chk("flush main noskid", out_data0, 64'h0000_0040_0000_0013);
    chk("flush out_valid", 64'(out_valid1), 64'd0);
    chk("flush count", 64'(count1), 64'd0);
    cyc(0, 0, 1);
    chk("flushed input absent", 64'(count1), 64'd0);

    // hold while ONE
    cyc(1, 64'h4444, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 64'h5555, 1, 1);
      chk("hold in_ready", 64'(in_ready1), 64'd0);
      chk("hold out_valid", 64'(out_valid1), 64'd0);
      chk("hold data", out_data1, 64'h4444);
      chk("hold count", 64'(count1), 64'd1);
    end
    cyc(1, 64'h5555, 1);
    chk("hold release data", out_data1, 64'h5555);
    cyc(0, 0, 1);

    // asynchronous reset between edges while FULL
    cyc(1, 64'h6666, 0);
    cyc(1, 64'h7777, 0);
    #1 reset = 1;
    #1;
    chk("async out_valid", 64'(out_valid1), 64'd0);
    chk("async out_data", out_data1, NOP);
    chk("async count", 64'(count1), 64'd0);
    @(posedge clk); #2 reset = 0;

    // mixed traffic
    for (int i = 0; i < 40; i++)
      cyc(i % 4 != 3, 64'h0000_0100_0000_A000 + 64'(i), i % 3 != 1, i % 11 == 5, i == 23);
    cyc(0, 0, 1);
    cyc(0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
